// File: rtl/sub_serial_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the 2-bit state encoding used across the serial-arithmetic blocks
// and the small pure functions that describe the result flags.
package sub_serial_pkg;

    // 2-bit state encoding shared with the serial adder; 2'd3 is never
    // entered on purpose and is steered back to IDLE by the FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2,
        ST_RSVD = 2'd3
    } state_t;

    // Width of the bit counter for a given operand width.
    function automatic int unsigned count_width(input int unsigned width);
        return (width < 32'd2) ? 32'd1 : $clog2(width);
    endfunction

    // Full-subtractor difference bit.
    function automatic logic fsub_diff(input logic x, input logic y, input logic bin);
        return x ^ y ^ bin;
    endfunction

    // Full-subtractor borrow-out: borrow when x < y + bin.
    function automatic logic fsub_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~x & bin) | (y & bin);
    endfunction

    // Two's-complement overflow of a - b: operands of opposite sign and
    // a result whose sign differs from the minuend.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                          input logic res_msb);
        return (a_msb != b_msb) && (res_msb != a_msb);
    endfunction

endpackage : sub_serial_pkg

// File: rtl/sub_serial_fsub_bit.sv
// Combinational full-subtractor cell: d = a - b - bin (one bit), bout = borrow.
// The serial subtractor instantiates exactly one of these on the LSBs of the
// shifting operand registers and the stored borrow.
module fsub_bit
    import sub_serial_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    logic w_d;
    logic w_bout;

    // Difference and borrow for the current bit position.
    always_comb begin
        w_d    = 1'b0;
        w_bout = 1'b0;
        w_d    = fsub_diff(i_a, i_b, i_bin);
        w_bout = fsub_borrow(i_a, i_b, i_bin);
    end

    assign o_d    = w_d;
    assign o_bout = w_bout;

endmodule : fsub_bit

// File: rtl/sub_serial.sv
// Bit-serial subtractor: latches a and b on a start request, then produces
// a - b LSB-first, one bit per clock, shifting each difference bit into the
// MSB of the result register. After WIDTH bit steps the result, the final
// unsigned borrow and the signed-overflow flag are held in DONE until en
// drops. busy/done are decoded from the state register only.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [WIDTH-1:0] ZERO_W = WIDTH'(0);

    // State and datapath registers.
    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [CW-1:0]    r_count;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_out;
    logic             r_borrow_out;
    logic             r_ovf;

    // Bit-step combinational results.
    logic w_d;
    logic w_bout;
    logic w_last;

    fsub_bit u_fsub_bit (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    assign w_last = (r_count == LAST_CNT);

    // Control FSM: IDLE -> SUB on en, SUB -> DONE after the last bit,
    // DONE -> IDLE once en drops; the unused encoding recovers to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state <= ST_SUB;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SUB: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_SUB;
                    end
                end
                ST_DONE: begin
                    if (en) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: operand capture on start, one subtract step per SUB cycle,
    // flag capture on the last step; everything holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a          <= ZERO_W;
            r_b          <= ZERO_W;
            r_borrow     <= 1'b0;
            r_count      <= CNT_ZERO;
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_out        <= ZERO_W;
            r_borrow_out <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_a          <= a;
                        r_b          <= b;
                        r_a_msb      <= a[WIDTH-1];
                        r_b_msb      <= b[WIDTH-1];
                        r_borrow     <= 1'b0;
                        r_count      <= CNT_ZERO;
                        r_out        <= ZERO_W;
                        r_borrow_out <= 1'b0;
                        r_ovf        <= 1'b0;
                    end else begin
                        r_a <= r_a;
                    end
                end
                ST_SUB: begin
                    r_out    <= {w_d, r_out[WIDTH-1:1]};
                    r_a      <= {1'b0, r_a[WIDTH-1:1]};
                    r_b      <= {1'b0, r_b[WIDTH-1:1]};
                    r_borrow <= w_bout;
                    r_count  <= r_count + CNT_ONE;
                    if (w_last) begin
                        // w_d is the result MSB on this final step.
                        r_borrow_out <= w_bout;
                        r_ovf        <= sub_overflow(r_a_msb, r_b_msb, w_d);
                    end else begin
                        r_borrow_out <= r_borrow_out;
                    end
                end
                ST_DONE: begin
                    r_out <= r_out;
                end
                default: begin
                    r_out <= r_out;
                end
            endcase
        end
    end

    assign out        = r_out;
    assign borrow_out = r_borrow_out;
    assign ovf        = r_ovf;
    assign busy       = (r_state == ST_SUB);
    assign done       = (r_state == ST_DONE);

endmodule : sub_serial
